// File: rtl/de_ex_pipe_reg_pkg.sv
// Shared constants and types for the decode-to-execute pipeline register:
// controller codes, default widths, bubble values and the per-edge update action.
package de_ex_pipe_reg_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int RIDX_DEF  = 5;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ALU_OP_ADD    = 2'b00,
        ALU_OP_BRANCH = 2'b01,
        ALU_OP_RTYPE  = 2'b10,
        ALU_OP_ITYPE  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ALU_SRC2_RS2  = 2'b00,
        ALU_SRC2_IMM  = 2'b01,
        ALU_SRC2_PC4  = 2'b10,
        ALU_SRC2_ZERO = 2'b11
    } alu_src2_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [1:0] alu_op;
        logic [1:0] alu_src2;
        logic       brn_cond;
        logic       mem_we;
        logic       de_we;
        logic       mem_reg;
    } ctrl_t;

    localparam ctrl_t      CTRL_BUBBLE    = '0;
    localparam logic       VALID_BUBBLE   = 1'b0;
    localparam logic [2:0] FUNCT3_BUBBLE  = 3'b000;
    localparam logic       FUNCT7B5_BUBBLE = 1'b0;

    typedef enum logic [1:0] {
        UPD_CAPTURE,
        UPD_HOLD,
        UPD_LU_BUBBLE,
        UPD_FLUSH_BUBBLE
    } upd_e;

    // An invalid decode slot must never write state, so its enables are stripped.
    function automatic ctrl_t kill_enables(input ctrl_t c);
        ctrl_t r;
        r          = c;
        r.brn_cond = 1'b0;
        r.mem_we   = 1'b0;
        r.de_we    = 1'b0;
        r.mem_reg  = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/de_ex_pipe_reg_hazard_detect_lu.sv
// Load-use hazard compare: a load in EX whose destination feeds either decode source.
module hazard_detect_lu
    import de_ex_pipe_reg_pkg::*;
#(
    parameter int RIDX = RIDX_DEF
) (
    input  logic            e_valid,
    input  logic            e_mem_reg,
    input  logic            e_de_we,
    input  logic [RIDX-1:0] e_rd,
    input  logic            d_valid,
    input  logic [RIDX-1:0] d_rs1,
    input  logic [RIDX-1:0] d_rs2,
    output logic            load_use
);

    logic loadInEx;
    logic srcMatch;

    // Both sources are compared even if unused; the occasional false stall is harmless.
    assign loadInEx = e_valid & e_mem_reg & e_de_we & (e_rd != '0);
    assign srcMatch = (e_rd == d_rs1) | (e_rd == d_rs2);
    assign load_use = loadInEx & d_valid & srcMatch;

endmodule

// File: rtl/de_ex_pipe_reg.sv
// Decode-to-execute pipeline register with load-use bubble insertion, branch flush,
// downstream-stall hold and a saturating count of load-use bubbles.
module de_ex_pipe_reg
    import de_ex_pipe_reg_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int RIDX  = RIDX_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic [XLEN-1:0]  d_pc,
    input  logic [XLEN-1:0]  d_rs1_val,
    input  logic [XLEN-1:0]  d_rs2_val,
    input  logic [XLEN-1:0]  d_imm,
    input  logic [RIDX-1:0]  d_rs1,
    input  logic [RIDX-1:0]  d_rs2,
    input  logic [RIDX-1:0]  d_rd,
    input  logic [2:0]       d_funct3,
    input  logic             d_funct7b5,
    input  logic [1:0]       d_alu_op,
    input  logic [1:0]       d_alu_src2,
    input  logic             d_brn_cond,
    input  logic             d_mem_we,
    input  logic             d_de_we,
    input  logic             d_mem_reg,
    input  logic             flush,
    input  logic             ex_stall,
    output logic             e_valid,
    output logic [XLEN-1:0]  e_pc,
    output logic [XLEN-1:0]  e_rs1_val,
    output logic [XLEN-1:0]  e_rs2_val,
    output logic [XLEN-1:0]  e_imm,
    output logic [RIDX-1:0]  e_rs1,
    output logic [RIDX-1:0]  e_rs2,
    output logic [RIDX-1:0]  e_rd,
    output logic [2:0]       e_funct3,
    output logic             e_funct7b5,
    output logic [1:0]       e_alu_op,
    output logic [1:0]       e_alu_src2,
    output logic             e_brn_cond,
    output logic             e_mem_we,
    output logic             e_de_we,
    output logic             e_mem_reg,
    output logic             load_use_stall,
    output logic [CNT_W-1:0] bubble_count
);

    logic             valid_q,    valid_d;
    logic [XLEN-1:0]  pc_q,       pc_d;
    logic [XLEN-1:0]  rs1_val_q,  rs1_val_d;
    logic [XLEN-1:0]  rs2_val_q,  rs2_val_d;
    logic [XLEN-1:0]  imm_q,      imm_d;
    logic [RIDX-1:0]  rs1_q,      rs1_d;
    logic [RIDX-1:0]  rs2_q,      rs2_d;
    logic [RIDX-1:0]  rd_q,       rd_d;
    logic [2:0]       funct3_q,   funct3_d;
    logic             funct7b5_q, funct7b5_d;
    ctrl_t            ctrl_q,     ctrl_d;
    logic [CNT_W-1:0] count_q,    count_d;

    ctrl_t            dCtrl;
    logic             loadUse;
    upd_e             upd;

    assign dCtrl = '{alu_op:   d_alu_op,
                     alu_src2: d_alu_src2,
                     brn_cond: d_brn_cond,
                     mem_we:   d_mem_we,
                     de_we:    d_de_we,
                     mem_reg:  d_mem_reg};

    hazard_detect_lu #(
        .RIDX (RIDX)
    ) u_hazard (
        .e_valid   (valid_q),
        .e_mem_reg (ctrl_q.mem_reg),
        .e_de_we   (ctrl_q.de_we),
        .e_rd      (rd_q),
        .d_valid   (d_valid),
        .d_rs1     (d_rs1),
        .d_rs2     (d_rs2),
        .load_use  (loadUse)
    );

    // A flush or a downstream stall pre-empts the hazard, so decode is only frozen otherwise.
    assign load_use_stall = loadUse & ~flush & ~ex_stall;

    always_comb begin
        upd = UPD_CAPTURE;
        if (flush) begin
            upd = UPD_FLUSH_BUBBLE;
        end else if (ex_stall) begin
            upd = UPD_HOLD;
        end else if (loadUse) begin
            upd = UPD_LU_BUBBLE;
        end
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_val_d  = rs1_val_q;
        rs2_val_d  = rs2_val_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        funct3_d   = funct3_q;
        funct7b5_d = funct7b5_q;
        ctrl_d     = ctrl_q;
        count_d    = count_q;
        unique case (upd)
            UPD_CAPTURE: begin
                valid_d    = d_valid;
                pc_d       = d_pc;
                rs1_val_d  = d_rs1_val;
                rs2_val_d  = d_rs2_val;
                imm_d      = d_imm;
                rs1_d      = d_rs1;
                rs2_d      = d_rs2;
                rd_d       = d_rd;
                funct3_d   = d_funct3;
                funct7b5_d = d_funct7b5;
                ctrl_d     = d_valid ? dCtrl : kill_enables(dCtrl);
            end
            UPD_HOLD: begin
            end
            UPD_LU_BUBBLE, UPD_FLUSH_BUBBLE: begin
                valid_d    = VALID_BUBBLE;
                pc_d       = '0;
                rs1_val_d  = '0;
                rs2_val_d  = '0;
                imm_d      = '0;
                rs1_d      = '0;
                rs2_d      = '0;
                rd_d       = '0;
                funct3_d   = FUNCT3_BUBBLE;
                funct7b5_d = FUNCT7B5_BUBBLE;
                ctrl_d     = CTRL_BUBBLE;
                if (upd == UPD_LU_BUBBLE && count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= VALID_BUBBLE;
            pc_q       <= '0;
            rs1_val_q  <= '0;
            rs2_val_q  <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= FUNCT3_BUBBLE;
            funct7b5_q <= FUNCT7B5_BUBBLE;
            ctrl_q     <= CTRL_BUBBLE;
            count_q    <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_val_q  <= rs1_val_d;
            rs2_val_q  <= rs2_val_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            funct3_q   <= funct3_d;
            funct7b5_q <= funct7b5_d;
            ctrl_q     <= ctrl_d;
            count_q    <= count_d;
        end
    end

    assign e_valid      = valid_q;
    assign e_pc         = pc_q;
    assign e_rs1_val    = rs1_val_q;
    assign e_rs2_val    = rs2_val_q;
    assign e_imm        = imm_q;
    assign e_rs1        = rs1_q;
    assign e_rs2        = rs2_q;
    assign e_rd         = rd_q;
    assign e_funct3     = funct3_q;
    assign e_funct7b5   = funct7b5_q;
    assign e_alu_op     = ctrl_q.alu_op;
    assign e_alu_src2   = ctrl_q.alu_src2;
    assign e_brn_cond   = ctrl_q.brn_cond;
    assign e_mem_we     = ctrl_q.mem_we;
    assign e_de_we      = ctrl_q.de_we;
    assign e_mem_reg    = ctrl_q.mem_reg;
    assign bubble_count = count_q;

endmodule

// File: tb/tb_de_ex_pipe_reg.sv
// Bench for de_ex_pipe_reg: directed scenarios followed by random traffic, all
// checked against a cycle-level reference model of the pipeline register.
module tb_de_ex_pipe_reg;

    localparam int XLEN  = 32;
    localparam int RIDX  = 5;
    // Narrow counter so saturation is reachable in a short run.
    localparam int CNT_W = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             d_valid;
    logic [XLEN-1:0]  d_pc, d_rs1_val, d_rs2_val, d_imm;
    logic [RIDX-1:0]  d_rs1, d_rs2, d_rd;
    logic [2:0]       d_funct3;
    logic             d_funct7b5;
    logic [1:0]       d_alu_op, d_alu_src2;
    logic             d_brn_cond, d_mem_we, d_de_we, d_mem_reg;
    logic             flush, ex_stall;
    logic             e_valid;
    logic [XLEN-1:0]  e_pc, e_rs1_val, e_rs2_val, e_imm;
    logic [RIDX-1:0]  e_rs1, e_rs2, e_rd;
    logic [2:0]       e_funct3;
    logic             e_funct7b5;
    logic [1:0]       e_alu_op, e_alu_src2;
    logic             e_brn_cond, e_mem_we, e_de_we, e_mem_reg;
    logic             load_use_stall;
    logic [CNT_W-1:0] bubble_count;

    typedef struct {
        logic            valid;
        logic [XLEN-1:0] pc, rs1v, rs2v, imm;
        logic [RIDX-1:0] rs1, rs2, rd;
        logic [2:0]      f3;
        logic            f7;
        logic [1:0]      aop, asrc;
        logic            brn, mwe, dwe, mreg;
    } stage_t;

    stage_t m;
    int     mCount;
    int     nChecks;
    int     nFail;

    de_ex_pipe_reg #(.XLEN(XLEN), .RIDX(RIDX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_pc(d_pc),
        .d_rs1_val(d_rs1_val), .d_rs2_val(d_rs2_val), .d_imm(d_imm),
        .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_funct3(d_funct3),
        .d_funct7b5(d_funct7b5), .d_alu_op(d_alu_op), .d_alu_src2(d_alu_src2),
        .d_brn_cond(d_brn_cond), .d_mem_we(d_mem_we), .d_de_we(d_de_we),
        .d_mem_reg(d_mem_reg), .flush(flush), .ex_stall(ex_stall),
        .e_valid(e_valid), .e_pc(e_pc), .e_rs1_val(e_rs1_val),
        .e_rs2_val(e_rs2_val), .e_imm(e_imm), .e_rs1(e_rs1), .e_rs2(e_rs2),
        .e_rd(e_rd), .e_funct3(e_funct3), .e_funct7b5(e_funct7b5),
        .e_alu_op(e_alu_op), .e_alu_src2(e_alu_src2), .e_brn_cond(e_brn_cond),
        .e_mem_we(e_mem_we), .e_de_we(e_de_we), .e_mem_reg(e_mem_reg),
        .load_use_stall(load_use_stall), .bubble_count(bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp)
        else begin
            nFail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic stage_t bubble();
        stage_t b;
        b = '{default: '0};
        return b;
    endfunction

    // A dependent instruction behind a register-writing load in EX must wait one cycle.
    function automatic logic modelHazard();
        return m.valid && m.mreg && m.dwe && (m.rd != 0) && d_valid &&
               ((m.rd == d_rs1) || (m.rd == d_rs2));
    endfunction

    task automatic checkOutput();
        check("e_valid",      e_valid,      m.valid);
        check("e_pc",         e_pc,         m.pc);
        check("e_rs1_val",    e_rs1_val,    m.rs1v);
        check("e_rs2_val",    e_rs2_val,    m.rs2v);
        check("e_imm",        e_imm,        m.imm);
        check("e_rs1",        e_rs1,        m.rs1);
        check("e_rs2",        e_rs2,        m.rs2);
        check("e_rd",         e_rd,         m.rd);
        check("e_funct3",     e_funct3,     m.f3);
        check("e_funct7b5",   e_funct7b5,   m.f7);
        check("e_alu_op",     e_alu_op,     m.aop);
        check("e_alu_src2",   e_alu_src2,   m.asrc);
        check("e_brn_cond",   e_brn_cond,   m.brn);
        check("e_mem_we",     e_mem_we,     m.mwe);
        check("e_de_we",      e_de_we,      m.dwe);
        check("e_mem_reg",    e_mem_reg,    m.mreg);
        check("bubble_count", bubble_count, 64'(mCount));
    endtask

    // One clock: check the hazard output, advance the model, then check the stage.
    task automatic cycle();
        stage_t nxt;
        logic   hz;
        #1;
        hz = modelHazard();
        check("load_use_stall", load_use_stall, hz && !flush && !ex_stall);
        nxt = m;
        if (flush) begin
            nxt = bubble();
        end else if (ex_stall) begin
            nxt = m;
        end else if (hz) begin
            nxt = bubble();
            if (mCount < CNT_MAX) mCount++;
        end else begin
            nxt.valid = d_valid;   nxt.pc   = d_pc;      nxt.rs1v = d_rs1_val;
            nxt.rs2v  = d_rs2_val; nxt.imm  = d_imm;     nxt.rs1  = d_rs1;
            nxt.rs2   = d_rs2;     nxt.rd   = d_rd;      nxt.f3   = d_funct3;
            nxt.f7    = d_funct7b5; nxt.aop = d_alu_op;  nxt.asrc = d_alu_src2;
            nxt.brn   = d_valid & d_brn_cond;
            nxt.mwe   = d_valid & d_mem_we;
            nxt.dwe   = d_valid & d_de_we;
            nxt.mreg  = d_valid & d_mem_reg;
        end
        @(posedge clk);
        m = nxt;
        @(negedge clk);
        checkOutput();
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic load, input logic we);
        d_valid    = v;
        d_pc       = pc;
        d_rs1_val  = pc ^ 32'hA5A5_0000;
        d_rs2_val  = pc ^ 32'h0000_5A5A;
        d_imm      = pc + 32'h10;
        d_rs1      = rs1;
        d_rs2      = rs2;
        d_rd       = rd;
        d_funct3   = pc[2:0];
        d_funct7b5 = pc[3];
        d_alu_op   = load ? 2'b00 : 2'b10;
        d_alu_src2 = load ? 2'b01 : 2'b00;
        d_brn_cond = 1'b0;
        d_mem_we   = 1'b0;
        d_de_we    = we;
        d_mem_reg  = load;
    endtask

    task automatic applyRandom();
        d_valid    = ($urandom_range(0, 9) < 8);
        d_pc       = $urandom;
        d_rs1_val  = $urandom;
        d_rs2_val  = $urandom;
        d_imm      = $urandom;
        d_rs1      = 5'($urandom_range(0, 7));
        d_rs2      = 5'($urandom_range(0, 7));
        d_rd       = 5'($urandom_range(0, 7));
        d_funct3   = 3'($urandom);
        d_funct7b5 = 1'($urandom);
        d_alu_op   = 2'($urandom);
        d_alu_src2 = 2'($urandom);
        d_brn_cond = 1'($urandom);
        d_mem_we   = 1'($urandom);
        d_de_we    = ($urandom_range(0, 3) != 0);
        d_mem_reg  = ($urandom_range(0, 1) != 0);
        flush      = ($urandom_range(0, 9) == 0);
        ex_stall   = ($urandom_range(0, 6) == 0);
    endtask

    task automatic asyncReset();
        rst = 1'b1;
        #1;
        m = bubble();
        mCount = 0;
        checkOutput();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        nChecks = 0;
        nFail   = 0;
        mCount  = 0;
        m       = bubble();
        rst     = 1'b1;
        flush   = 1'b0;
        ex_stall = 1'b0;
        applyStimulus(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        $display("[TB] reset");
        repeat (2) @(negedge clk);
        checkOutput();
        rst = 1'b0;
        cycle();
        check("reset_lus", load_use_stall, 1'b0);

        $display("[TB] straight-line capture");
        applyStimulus(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
        cycle();
        check("cap_pc", e_pc, 32'h100);
        check("cap_rd", e_rd, 5'd3);
        check("cap_valid", e_valid, 1'b1);

        $display("[TB] load-use");
        applyStimulus(1'b1, 32'h104, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
        cycle();
        applyStimulus(1'b1, 32'h108, 5'd6, 5'd5, 5'd7, 1'b0, 1'b1);
        #1;
        check("lu_stall_high", load_use_stall, 1'b1);
        cycle();
        check("lu_bubble_valid", e_valid, 1'b0);
        check("lu_bubble_count", bubble_count, 10'd1);
        cycle();
        check("lu_held_pc", e_pc, 32'h108);
        check("lu_stall_low", load_use_stall, 1'b0);

        $display("[TB] load to x0");
        applyStimulus(1'b1, 32'h10C, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1);
        cycle();
        applyStimulus(1'b1, 32'h110, 5'd0, 5'd0, 5'd4, 1'b0, 1'b1);
        cycle();
        check("x0_count", bubble_count, 10'd1);
        check("x0_pc", e_pc, 32'h110);

        $display("[TB] ex_stall hold, then flush with stall");
        applyStimulus(1'b1, 32'h200, 5'd1, 5'd2, 5'd9, 1'b0, 1'b1);
        cycle();
        ex_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i * 4), 5'd3, 5'd4, 5'd10, 1'b0, 1'b1);
            cycle();
            check("stall_pc_frozen", e_pc, 32'h200);
        end
        flush = 1'b1;
        cycle();
        check("flush_valid", e_valid, 1'b0);
        check("flush_count", bubble_count, 10'd1);
        flush = 1'b0;
        ex_stall = 1'b0;

        $display("[TB] bubble counter saturation");
        asyncReset();
        applyStimulus(1'b1, 32'h400, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1);
        for (int i = 0; i < 2 * CNT_MAX + 10; i++) cycle();
        check("sat_count", bubble_count, 10'h3FF);

        $display("[TB] mid-cycle reset");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        m = bubble();
        mCount = 0;
        checkOutput();
        check("midrst_lus", load_use_stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 32'h500, 5'd1, 5'd2, 5'd8, 1'b0, 1'b1);
        cycle();
        check("post_rst_pc", e_pc, 32'h500);

        $display("[TB] random traffic");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) asyncReset();
            applyRandom();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
